uart_rx_err_monitor: RTL
========================

Name: uart_rx_err_monitor

Overview:
Registered, parametrised error monitor for the UART RX path, placed between the RX FIFO read port and the APB register/interrupt logic. It takes each popped FIFO word and splits it into data, parity and error fields. It produces per-frame error flags, a slave-error pulse, sticky status bits, saturating per-type error counters, burst-error detection and a maskable interrupt.

Parameters:
DATA_W, 8, data bits per frame. The FIFO word is DATA_W+4 bits wide.
COUNT_W, 8, width of each saturating error counter.
BURST_LEN, 4, number of consecutive errored frames that flags a burst. Legal range is 2 to 255.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
frame_valid  in  1  frame_in holds a popped FIFO word this cycle
frame_in  in  DATA_W+4  fields: [DATA_W-1:0] data, [DATA_W] parity, [DATA_W+1] overrun (OE), [DATA_W+2] break (BE), [DATA_W+3] framing (FE)
err_en  in  4  interrupt enables: bit0 OE, bit1 BE, bit2 FE, bit3 burst
clr_valid  in  1  clear strobe
clr_mask  in  4  selects what clr_valid clears; same bit order as err_en
data_valid  out  1  registered copy of frame_valid
data_out  out  DATA_W  registered data field
parity_out  out  1  registered parity field
OE  out  1  per-frame overrun flag; qualified by data_valid
BE  out  1  per-frame break flag; qualified by data_valid
FE  out  1  per-frame framing flag; qualified by data_valid
PUARTERR  out  1  OE | BE | FE, registered, high only while data_valid is high
sticky  out  4  sticky status: {burst, FE, BE, OE}
oe_cnt  out  COUNT_W  overrun error count
be_cnt  out  COUNT_W  break error count
fe_cnt  out  COUNT_W  framing error count
irq  out  1  |(sticky & err_en), registered

Behaviour:
- Reset: every output and internal register is 0, and the burst FSM is in IDLE. rst takes priority over every other input.
- Pipeline: latency is 1 cycle. On a valid cycle, data_out, parity_out, OE, BE and FE load from frame_in.
- When frame_valid is 0: data_valid, OE, BE, FE and PUARTERR go to 0 next cycle. data_out and parity_out hold their last value.
- Sticky bits: bit k sets on the cycle after a valid frame with that error. Once set, it stays set until cleared by clr_valid with clr_mask[k] high.
- Set and clear of the same sticky bit in the same cycle: set wins, so the bit stays 1.
- Counters: each counter increments by 1 per valid frame carrying that error. A frame with several error bits increments every matching counter.
- Counter saturation: counters saturate at 2^COUNT_W-1 and do not wrap.
- Counter clear: clr_mask bits 0-2 also zero the matching counter.
- Clear and increment of the same counter in the same cycle: the counter loads 1.
- Burst FSM, with internal run counter run (8 bits):
  - IDLE: a valid errored frame sets run=1 and moves to RUN. Clean frames keep it in IDLE.
  - RUN: a valid errored frame increments run. When run+1 == BURST_LEN, set sticky[3] and move to LOCKED. A valid clean frame sets run=0 and returns to IDLE.
  - LOCKED: errored frames are ignored and run holds. A valid clean frame sets run=0 and returns to IDLE.
  - The FSM re-arms only after a clean frame, so one burst flags only once.
- clr_mask[3] clears sticky[3] only. It does not change the FSM state, so a continuing burst does not re-flag. Set-wins applies to sticky[3] as well.
- irq is high on the cycle after any enabled sticky bit is high. It is level-sensitive and drops the cycle after the sticky bit clears or its err_en bit clears.
- Error masking: err_en gates irq only. Sticky bits and counters always update.
- Reset mid-operation: a frame presented in the same cycle as rst is dropped entirely and changes no counter, sticky bit or FSM state.

Decomposition:
- Shared package uart_pkg:
  - field offset constants OE_BIT=DATA_W+1, BE_BIT=DATA_W+2, FE_BIT=DATA_W+3
  - sticky/enable index constants IDX_OE=0, IDX_BE=1, IDX_FE=2, IDX_BURST=3
  - burst FSM state enum {IDLE, RUN, LOCKED}
- Sub-module: uart_sat_counter (COUNT_W; inc, clr, count), instantiated three times. Clear-plus-increment loads 1.
- Burst FSM and sticky/irq logic stay in the top module.

Test Plan:
- Reset, then one valid frame with DATA_W=8, frame_in=12'h2A5 (OE=1). Next cycle: data_valid=1, data_out=8'hA5, parity_out=0, OE=1, PUARTERR=1, oe_cnt=1, sticky=4'b0001. With err_en=4'b0001, irq=1 one cycle after sticky.
- One frame with FE and BE both set (12'hC00), then clr_valid with clr_mask=4'b0100 on the same cycle as a second FE frame. Result: fe_cnt=1, be_cnt=1, sticky[2] stays 1 because set wins.
- COUNT_W=4; drive 20 consecutive BE frames. be_cnt stops at 15, and the 16th to 20th frames leave it at 15.
- BURST_LEN=4; frames err, err, clean, err, err, err, err. sticky[3] sets only after the 7th frame. Clear it with clr_mask=4'b1000, then send 2 more errored frames: sticky[3] stays 0. Send clean, then 4 errored frames: sticky[3] sets again.
- err_en=0 with an errored frame: sticky updates and irq stays 0. Then set err_en=4'b0010 with BE sticky already set: irq rises next cycle.
- Assert rst mid-burst with a frame present and counters non-zero. Next cycle: all outputs are 0, the FSM is in IDLE, and the dropped frame is not counted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and types for the UART RX error monitor.
package uart_pkg;

    // Sticky-status / interrupt-enable bit positions
    localparam int unsigned IDX_OE    = 0;
    localparam int unsigned IDX_BE    = 1;
    localparam int unsigned IDX_FE    = 2;
    localparam int unsigned IDX_BURST = 3;
    localparam int unsigned N_STATUS  = 4;

    // Burst detector states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        LOCKED = 2'd2
    } burst_state_e;

    // FIFO word field offsets, relative to the data width
    function automatic int unsigned oe_bit(input int unsigned data_w);
        return data_w + 1;
    endfunction

    function automatic int unsigned be_bit(input int unsigned data_w);
        return data_w + 2;
    endfunction

    function automatic int unsigned fe_bit(input int unsigned data_w);
        return data_w + 3;
    endfunction

endpackage

// File: rtl/uart_sat_counter.sv
// Saturating up-counter with synchronous clear; clear plus increment loads 1.
module uart_sat_counter #(
    parameter int unsigned COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    input  logic               clr,
    output logic [COUNT_W-1:0] count
);

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    // Count register: clear dominates increment, increment stops at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? COUNT_W'(1) : '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + COUNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_err_monitor.sv
// Error monitor between the UART RX FIFO read port and the APB status/IRQ logic.
module uart_rx_err_monitor
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned COUNT_W   = 8,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_valid,
    input  logic [DATA_W+3:0]  frame_in,
    input  logic [3:0]         err_en,
    input  logic               clr_valid,
    input  logic [3:0]         clr_mask,
    output logic               data_valid,
    output logic [DATA_W-1:0]  data_out,
    output logic               parity_out,
    output logic               OE,
    output logic               BE,
    output logic               FE,
    output logic               PUARTERR,
    output logic [3:0]         sticky,
    output logic [COUNT_W-1:0] oe_cnt,
    output logic [COUNT_W-1:0] be_cnt,
    output logic [COUNT_W-1:0] fe_cnt,
    output logic               irq
);

    localparam int unsigned OE_BIT = oe_bit(DATA_W);
    localparam int unsigned BE_BIT = be_bit(DATA_W);
    localparam int unsigned FE_BIT = fe_bit(DATA_W);
    localparam int unsigned RUN_W  = 8;
    localparam logic [RUN_W-1:0] BURST_LEN_C = RUN_W'(BURST_LEN);

    logic                 frm_oe_c;
    logic                 frm_be_c;
    logic                 frm_fe_c;
    logic                 frm_err_c;
    burst_state_e         state_q;
    burst_state_e         state_d;
    logic [RUN_W-1:0]     run_q;
    logic [RUN_W-1:0]     run_d;
    logic                 burst_set_c;
    logic [N_STATUS-1:0]  sticky_set_c;
    logic [N_STATUS-1:0]  sticky_clr_c;

    // Field extraction from the popped FIFO word
    always_comb begin
        frm_oe_c  = frame_in[OE_BIT];
        frm_be_c  = frame_in[BE_BIT];
        frm_fe_c  = frame_in[FE_BIT];
        frm_err_c = frm_oe_c | frm_be_c | frm_fe_c;
    end

    // One-cycle output pipeline; data and parity hold across idle cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            data_valid <= 1'b0;
            data_out   <= '0;
            parity_out <= 1'b0;
            OE         <= 1'b0;
            BE         <= 1'b0;
            FE         <= 1'b0;
            PUARTERR   <= 1'b0;
        end else begin
            data_valid <= frame_valid;
            OE         <= frame_valid & frm_oe_c;
            BE         <= frame_valid & frm_be_c;
            FE         <= frame_valid & frm_fe_c;
            PUARTERR   <= frame_valid & frm_err_c;
            if (frame_valid) begin
                data_out   <= frame_in[DATA_W-1:0];
                parity_out <= frame_in[DATA_W];
            end
        end
    end

    // Burst detector state and run-length register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    // Burst detector next state: flags once per run, re-arms on a clean frame
    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        burst_set_c = 1'b0;
        if (frame_valid) begin
            case (state_q)
                IDLE: begin
                    if (frm_err_c) begin
                        run_d   = RUN_W'(1);
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (frm_err_c) begin
                        run_d = run_q + RUN_W'(1);
                        if ((run_q + RUN_W'(1)) == BURST_LEN_C) begin
                            burst_set_c = 1'b1;
                            state_d     = LOCKED;
                        end
                    end else begin
                        run_d   = '0;
                        state_d = IDLE;
                    end
                end
                LOCKED: begin
                    if (!frm_err_c) begin
                        run_d   = '0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    run_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Sticky set/clear vectors in status bit order
    always_comb begin
        sticky_set_c            = '0;
        sticky_set_c[IDX_OE]    = frame_valid & frm_oe_c;
        sticky_set_c[IDX_BE]    = frame_valid & frm_be_c;
        sticky_set_c[IDX_FE]    = frame_valid & frm_fe_c;
        sticky_set_c[IDX_BURST] = burst_set_c;
        sticky_clr_c            = clr_valid ? clr_mask : '0;
    end

    // Sticky status (set wins over clear) and level interrupt from the registered sticky
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky <= '0;
            irq    <= 1'b0;
        end else begin
            sticky <= (sticky & ~sticky_clr_c) | sticky_set_c;
            irq    <= |(sticky & err_en);
        end
    end

    uart_sat_counter #(.COUNT_W(COUNT_W)) u_oe_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (sticky_set_c[IDX_OE]),
        .clr   (sticky_clr_c[IDX_OE]),
        .count (oe_cnt)
    );

    uart_sat_counter #(.COUNT_W(COUNT_W)) u_be_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (sticky_set_c[IDX_BE]),
        .clr   (sticky_clr_c[IDX_BE]),
        .count (be_cnt)
    );

    uart_sat_counter #(.COUNT_W(COUNT_W)) u_fe_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (sticky_set_c[IDX_FE]),
        .clr   (sticky_clr_c[IDX_FE]),
        .count (fe_cnt)
    );

endmodule
